sar_a2d_ctrl_multi: RTL and testbench

- Parametrised successor to the fixed two-channel 12-bit SAR A2D digital controller.
- Runs NCH successive-approximation conversions in parallel: one comparator input per channel, and a shared sample/settle timing engine whose timing is set by parameters.
- Optional 2^AVG_LOG2 oversample averaging.
- Optional offset-binary to two's-complement output conversion, which replaces the inline MSB-invert done at the instantiation site.
- Sits between the analog comparator/DAC pair and the digital core.

---
 rtl/sar_a2d_ctrl_multi.sv | 207 ++++++++++++++++++++
 tb/tb_sar_a2d_ctrl_multi.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_a2d_ctrl_multi.sv
// sar_a2d_ctrl_multi
// Multi-channel successive-approximation A2D digital controller. One shared
// sample/settle timing engine drives NCH parallel SAR registers, one
// comparator input per channel. It can optionally average 2^AVG_LOG2
// conversions per start request and optionally convert the offset-binary
// result to two's complement by inverting the MSB.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   strt_cnv   start request, honoured only when idle
//   abort      synchronous abort of a conversion in progress
//   gt[c]      comparator output for channel c (1: analog > DAC)
//   smpl       sample/hold command to the analog front end
//   sar        DAC drive words, channel c at [c*WIDTH +: WIDTH]
//   result     averaged, formatted result, same packing as sar
//   cnv_cmplt  one-cycle pulse when result updates
//   busy       high in every state except idle
module sar_a2d_ctrl_multi #(
  parameter int unsigned NCH        = 2,
  parameter int unsigned WIDTH      = 12,
  parameter int unsigned SMPL_CYC   = 4,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned AVG_LOG2   = 0,
  parameter int unsigned SIGNED_OUT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   strt_cnv,
  input  logic                   abort,
  input  logic [NCH-1:0]         gt,
  output logic                   smpl,
  output logic [NCH*WIDTH-1:0]   sar,
  output logic [NCH*WIDTH-1:0]   result,
  output logic                   cnv_cmplt,
  output logic                   busy
);

  localparam int unsigned MAXC     = (SMPL_CYC > SETTLE_CYC) ? SMPL_CYC : SETTLE_CYC;
  localparam int unsigned CW       = $clog2(MAXC + 1);
  localparam int unsigned IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned NW       = AVG_LOG2 + 1;
  localparam int unsigned AW       = WIDTH + AVG_LOG2;
  localparam int unsigned AVG_LAST = (1 << AVG_LOG2) - 1;

  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] FMT_MASK = (SIGNED_OUT != 0) ? MSB_MASK : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SMPL,
    S_TRIAL,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NW-1:0]     navg_q, navg_d;
  logic              smpl_q, smpl_d;
  logic              cmplt_q, cmplt_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  sar_q [NCH];
  logic [WIDTH-1:0]  sar_d [NCH];
  logic [AW-1:0]     acc_q [NCH];
  logic [AW-1:0]     acc_d [NCH];
  logic [WIDTH-1:0]  res_q [NCH];
  logic [WIDTH-1:0]  res_d [NCH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    navg_d  = navg_q;
    smpl_d  = smpl_q;
    cmplt_d = 1'b0;
    sar_d   = sar_q;
    acc_d   = acc_q;
    res_d   = res_q;

    unique case (state_q)
      S_IDLE: begin
        if (strt_cnv) begin
          state_d = S_SMPL;
          smpl_d  = 1'b1;
          cnt_d   = '0;
          navg_d  = '0;
          for (int unsigned c = 0; c < NCH; c++) begin
            sar_d[c] = '0;
            acc_d[c] = '0;
          end
        end
      end

      S_SMPL: begin
        if (cnt_q == CW'(SMPL_CYC - 1)) begin
          state_d = S_TRIAL;
          smpl_d  = 1'b0;
          cnt_d   = '0;
          idx_d   = IW'(WIDTH - 1);
          for (int unsigned c = 0; c < NCH; c++) sar_d[c] = MSB_MASK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_TRIAL: begin
        if (cnt_q == CW'(SETTLE_CYC - 1)) begin
          cnt_d = '0;
          // Resolve the current bit, then drop in the next trial bit in the
          // same edge so each bit gets a full settle window.
          for (int unsigned c = 0; c < NCH; c++) begin
            if (!gt[c]) sar_d[c][idx_q] = 1'b0;
            if (idx_q != '0) sar_d[c][idx_q - 1'b1] = 1'b1;
          end
          if (idx_q != '0) idx_d = idx_q - 1'b1;
          else             state_d = S_ACCUM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_ACCUM: begin
        for (int unsigned c = 0; c < NCH; c++) acc_d[c] = acc_q[c] + AW'(sar_q[c]);
        if (navg_q < NW'(AVG_LAST)) begin
          navg_d  = navg_q + 1'b1;
          state_d = S_SMPL;
          smpl_d  = 1'b1;
          cnt_d   = '0;
          for (int unsigned c = 0; c < NCH; c++) sar_d[c] = '0;
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        for (int unsigned c = 0; c < NCH; c++) res_d[c] = acc_q[c][AVG_LOG2 +: WIDTH] ^ FMT_MASK;
        cmplt_d = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Abort overrides whatever transition the state above chose.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      smpl_d  = 1'b0;
      cmplt_d = 1'b0;
      cnt_d   = '0;
      idx_d   = '0;
      navg_d  = '0;
      res_d   = res_q;
      for (int unsigned c = 0; c < NCH; c++) begin
        sar_d[c] = '0;
        acc_d[c] = '0;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      navg_q  <= '0;
      smpl_q  <= 1'b0;
      cmplt_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++) begin
        sar_q[c] <= '0;
        acc_q[c] <= '0;
        res_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      navg_q  <= navg_d;
      smpl_q  <= smpl_d;
      cmplt_q <= cmplt_d;
      busy_q  <= busy_d;
      for (int unsigned c = 0; c < NCH; c++) begin
        sar_q[c] <= sar_d[c];
        acc_q[c] <= acc_d[c];
        res_q[c] <= res_d[c];
      end
    end
  end

  always_comb begin
    sar    = '0;
    result = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      sar[c*WIDTH +: WIDTH]    = sar_q[c];
      result[c*WIDTH +: WIDTH] = res_q[c];
    end
  end

  assign smpl      = smpl_q;
  assign cnv_cmplt = cmplt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sar_a2d_ctrl_multi.sv
module tb_sar_a2d_ctrl_multi;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // dut_a: defaults (signed output)
  logic        strt_a, abort_a, smpl_a, cmplt_a, busy_a;
  logic [1:0]  gt_a;
  logic [23:0] sar_a, result_a;
  logic [11:0] vin_a [2];

  // dut_u: unsigned output
  logic        strt_u, abort_u, smpl_u, cmplt_u, busy_u;
  logic [1:0]  gt_u;
  logic [23:0] sar_u, result_u;
  logic [11:0] vin_u [2];

  // dut_v: 4x averaging, unsigned output
  logic        strt_v, abort_v, smpl_v, cmplt_v, busy_v;
  logic [1:0]  gt_v;
  logic [23:0] sar_v, result_v;
  logic [11:0] vin_v [2];

  // dut_w: 4 channels, 10 bits, settle 2
  logic        strt_w, abort_w, smpl_w, cmplt_w, busy_w;
  logic [3:0]  gt_w;
  logic [39:0] sar_w, result_w;
  logic [9:0]  vin_w [4];

  sar_a2d_ctrl_multi dut_a (
    .clk(clk), .rst_n(rst_n), .strt_cnv(strt_a), .abort(abort_a), .gt(gt_a),
    .smpl(smpl_a), .sar(sar_a), .result(result_a), .cnv_cmplt(cmplt_a), .busy(busy_a)
  );

  sar_a2d_ctrl_multi #(.SIGNED_OUT(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .strt_cnv(strt_u), .abort(abort_u), .gt(gt_u),
    .smpl(smpl_u), .sar(sar_u), .result(result_u), .cnv_cmplt(cmplt_u), .busy(busy_u)
  );

  sar_a2d_ctrl_multi #(.AVG_LOG2(2), .SIGNED_OUT(0)) dut_v (
    .clk(clk), .rst_n(rst_n), .strt_cnv(strt_v), .abort(abort_v), .gt(gt_v),
    .smpl(smpl_v), .sar(sar_v), .result(result_v), .cnv_cmplt(cmplt_v), .busy(busy_v)
  );

  sar_a2d_ctrl_multi #(.NCH(4), .WIDTH(10), .SETTLE_CYC(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .strt_cnv(strt_w), .abort(abort_w), .gt(gt_w),
    .smpl(smpl_w), .sar(sar_w), .result(result_w), .cnv_cmplt(cmplt_w), .busy(busy_w)
  );

  // Ideal comparators: analog input versus DAC word.
  always_comb begin
    gt_a = '0;
    gt_u = '0;
    gt_v = '0;
    gt_w = '0;
    for (int c = 0; c < 2; c++) begin
      gt_a[c] = (vin_a[c] >= sar_a[c*12 +: 12]);
      gt_u[c] = (vin_u[c] >= sar_u[c*12 +: 12]);
      gt_v[c] = (vin_v[c] >= sar_v[c*12 +: 12]);
    end
    for (int c = 0; c < 4; c++) gt_w[c] = (vin_w[c] >= sar_w[c*10 +: 10]);
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (smpl_a !== 1'b0) begin errors++; $display("FAIL reset_smpl got %b want 0", smpl_a); end
    checks++; if (sar_a !== 24'h0) begin errors++; $display("FAIL reset_sar got %h want 000000", sar_a); end
    checks++; if (result_a !== 24'h0) begin errors++; $display("FAIL reset_result got %h want 000000", result_a); end
    checks++; if (cmplt_a !== 1'b0) begin errors++; $display("FAIL reset_cmplt got %b want 0", cmplt_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
    checks++; if (result_w !== 40'h0) begin errors++; $display("FAIL reset_result_w got %h want 0", result_w); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", busy_a); end
  endtask

  task automatic test_basic();
    int lat, np;
    vin_a[0] = 12'hA5C;
    vin_a[1] = 12'h3FF;
    lat = -1; np = 0;
    strt_a = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      strt_a = 1'b0;
      if (cmplt_a === 1'b1) begin np++; if (lat < 0) lat = i; end
    end
    checks++; if (lat !== 102) begin errors++; $display("FAIL basic_latency got %0d want 102", lat); end
    checks++; if (np !== 1) begin errors++; $display("FAIL basic_pulses got %0d want 1", np); end
    checks++; if (result_a !== 24'hBFF25C) begin errors++; $display("FAIL basic_result got %h want bff25c", result_a); end
    checks++; if (sar_a !== 24'h3FFA5C) begin errors++; $display("FAIL basic_sar_hold got %h want 3ffa5c", sar_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", busy_a); end
  endtask

  task automatic test_boundary();
    int lat, nsmpl, nchg, misal;
    logic [23:0] prev;
    vin_u[0] = 12'h000;
    vin_u[1] = 12'hFFF;
    lat = -1; nsmpl = 0; nchg = 0; misal = 0;
    prev = sar_u;
    strt_u = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      strt_u = 1'b0;
      if (smpl_u === 1'b1) nsmpl++;
      if (sar_u !== prev) begin
        nchg++;
        if (i < 4 || ((i - 4) % 8) != 0) misal++;
        prev = sar_u;
      end
      if (cmplt_u === 1'b1 && lat < 0) lat = i;
    end
    checks++; if (lat !== 102) begin errors++; $display("FAIL bound_latency got %0d want 102", lat); end
    checks++; if (result_u !== 24'hFFF000) begin errors++; $display("FAIL bound_result got %h want fff000", result_u); end
    checks++; if (nsmpl !== 4) begin errors++; $display("FAIL bound_smpl_cycles got %0d want 4", nsmpl); end
    checks++; if (misal !== 0) begin errors++; $display("FAIL bound_sar_step_align got %0d want 0", misal); end
    checks++; if (nchg !== 13) begin errors++; $display("FAIL bound_sar_steps got %0d want 13", nchg); end
  endtask

  task automatic test_avg();
    int lat, np, nrise;
    logic prev_smpl;
    vin_v[0] = 12'h100;
    vin_v[1] = 12'h555;
    lat = -1; np = 0; nrise = 0;
    prev_smpl = 1'b0;
    strt_v = 1'b1;
    for (int i = 0; i < 450; i++) begin
      @(negedge clk);
      strt_v = 1'b0;
      if (smpl_v === 1'b1 && prev_smpl === 1'b0) begin
        vin_v[0] = 12'h100 + 12'(nrise);
        nrise++;
      end
      prev_smpl = smpl_v;
      if (cmplt_v === 1'b1) begin np++; if (lat < 0) lat = i; end
    end
    checks++; if (lat !== 405) begin errors++; $display("FAIL avg_latency got %0d want 405", lat); end
    checks++; if (np !== 1) begin errors++; $display("FAIL avg_pulses got %0d want 1", np); end
    checks++; if (nrise !== 4) begin errors++; $display("FAIL avg_smpl_pulses got %0d want 4", nrise); end
    checks++; if (result_v !== 24'h555101) begin errors++; $display("FAIL avg_result got %h want 555101", result_v); end
  endtask

  task automatic test_abort();
    int lat, np;
    vin_a[0] = 12'h123;
    vin_a[1] = 12'hF00;
    np = 0;
    strt_a = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      strt_a = 1'b0;
      if (i == 40) begin
        abort_a = 1'b0;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy_a); end
        checks++; if (sar_a !== 24'h0) begin errors++; $display("FAIL abort_sar got %h want 000000", sar_a); end
      end
      if (i == 39) abort_a = 1'b1;
      if (cmplt_a === 1'b1) np++;
    end
    checks++; if (np !== 0) begin errors++; $display("FAIL abort_no_cmplt got %0d want 0", np); end
    checks++; if (result_a !== 24'hBFF25C) begin errors++; $display("FAIL abort_result_kept got %h want bff25c", result_a); end

    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_idle_busy got %b want 0", busy_a); end

    // start and abort together while idle: start wins
    lat = -1;
    strt_a = 1'b1;
    abort_a = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      strt_a = 1'b0;
      abort_a = 1'b0;
      if (cmplt_a === 1'b1 && lat < 0) lat = i;
    end
    checks++; if (lat !== 102) begin errors++; $display("FAIL restart_latency got %0d want 102", lat); end
    checks++; if (result_a !== 24'h700923) begin errors++; $display("FAIL restart_result got %h want 700923", result_a); end
  endtask

  task automatic test_back_to_back();
    int lat, np;
    vin_a[0] = 12'h800;
    vin_a[1] = 12'h001;
    lat = -1; np = 0;
    strt_a = 1'b1;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      strt_a = (i == 9 || i == 49);
      if (cmplt_a === 1'b1) begin np++; if (lat < 0) lat = i; end
    end
    strt_a = 1'b0;
    checks++; if (lat !== 102) begin errors++; $display("FAIL busy_start_latency got %0d want 102", lat); end
    checks++; if (np !== 1) begin errors++; $display("FAIL busy_start_pulses got %0d want 1", np); end
    checks++; if (result_a !== 24'h801000) begin errors++; $display("FAIL busy_start_result got %h want 801000", result_a); end
  endtask

  task automatic test_reset_mid();
    vin_a[0] = 12'h456;
    vin_a[1] = 12'h789;
    strt_a = 1'b1;
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      strt_a = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (sar_a !== 24'h0) begin errors++; $display("FAIL rstmid_sar got %h want 000000", sar_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy_a); end
    checks++; if (result_a !== 24'h0) begin errors++; $display("FAIL rstmid_result got %h want 000000", result_a); end
    checks++; if (smpl_a !== 1'b0 || cmplt_a !== 1'b0) begin errors++; $display("FAIL rstmid_smpl_cmplt got %b%b want 00", smpl_a, cmplt_a); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rstmid_no_restart got %b want 0", busy_a); end
  endtask

  task automatic test_channels();
    int lat;
    logic [9:0] exp_w [4];
    vin_w[0] = 10'h3FF; exp_w[0] = 10'h1FF;
    vin_w[1] = 10'h000; exp_w[1] = 10'h200;
    vin_w[2] = 10'h2A5; exp_w[2] = 10'h0A5;
    vin_w[3] = 10'h15A; exp_w[3] = 10'h35A;
    lat = -1;
    strt_w = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      strt_w = 1'b0;
      if (cmplt_w === 1'b1 && lat < 0) lat = i;
    end
    checks++; if (lat !== 26) begin errors++; $display("FAIL chan_latency got %0d want 26", lat); end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (result_w[c*10 +: 10] !== exp_w[c]) begin
        errors++;
        $display("FAIL chan_result_%0d got %h want %h", c, result_w[c*10 +: 10], exp_w[c]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    strt_a = 1'b0; abort_a = 1'b0;
    strt_u = 1'b0; abort_u = 1'b0;
    strt_v = 1'b0; abort_v = 1'b0;
    strt_w = 1'b0; abort_w = 1'b0;
    for (int c = 0; c < 2; c++) begin
      vin_a[c] = '0;
      vin_u[c] = '0;
      vin_v[c] = '0;
    end
    for (int c = 0; c < 4; c++) vin_w[c] = '0;
    test_reset();
    test_basic();
    test_boundary();
    test_avg();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_channels();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
